// File: rtl/bus_pkg.sv
// Shared encodings for the two-master bus arbiter: FSM states, master IDs and the
// arbitration decision used in IDLE and HANDOVER.
package bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    OWN_M1   = 2'd1,
    OWN_M2   = 2'd2,
    HANDOVER = 2'd3
  } arb_state_e;

  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  // Returns {valid, winner}; a resuming (previously split) master beats everything else.
  function automatic logic [1:0] arbitrate(input logic [1:0] elig,
                                           input logic [1:0] resume_prio,
                                           input logic       last_owner,
                                           input logic       rr_en);
    logic [1:0] res;
    res = 2'b00;
    if (resume_prio[0] && elig[0]) begin
      res = {1'b1, M1};
    end else if (resume_prio[1] && elig[1]) begin
      res = {1'b1, M2};
    end else if (elig == 2'b01) begin
      res = {1'b1, M1};
    end else if (elig == 2'b10) begin
      res = {1'b1, M2};
    end else if (elig == 2'b11) begin
      res = {1'b1, (rr_en && (last_owner == M1)) ? M2 : M1};
    end
    return res;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Counts cycles of continuous bus ownership; saturates at HOLD_MAX-1 and flags expiry there.
module hold_timer #(
  parameter int unsigned TW       = 7,
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TW-1:0] Limit = TW'(HOLD_MAX - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != Limit)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == Limit);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: holds a grant for a whole transfer, parks split masters and
// always inserts one dead HANDOVER cycle between owners.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned HOLD_MAX = 64,
  parameter int unsigned TW       = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic       slave_split,
  input  logic [1:0] split_done,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       bus_busy,
  output logic [1:0] split_pending,
  output logic [1:0] arb_state
);

  arb_state_e state_q, state_d;
  logic [1:0] pend_q, pend_d;
  logic [1:0] prio_q, prio_d;
  logic       last_q, last_d;

  logic [1:0] elig;
  logic [1:0] done_hit;
  logic [1:0] win;
  logic       owning;
  logic       expired;

  assign elig     = {m2_request, m1_request} & ~pend_q;
  assign done_hit = split_done & pend_q;
  assign win      = arbitrate(elig, prio_q, last_q, RR_EN);
  assign owning   = (state_q == OWN_M1) || (state_q == OWN_M2);

  hold_timer #(
    .TW       (TW),
    .HOLD_MAX (HOLD_MAX)
  ) u_hold_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!owning),
    .enable  (owning),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q & ~done_hit;
    prio_d  = prio_q | done_hit;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE, HANDOVER: begin
        if (win[1]) begin
          state_d         = (win[0] == M2) ? OWN_M2 : OWN_M1;
          prio_d[win[0]]  = 1'b0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      OWN_M1: begin
        // A split on the owner overrides any simultaneous split_done for it.
        if (slave_split) pend_d[0] = 1'b1;
        if (!m1_request || slave_split || (expired && elig[1])) begin
          state_d = HANDOVER;
          last_d  = M1;
        end
      end
      OWN_M2: begin
        if (slave_split) pend_d[1] = 1'b1;
        if (!m2_request || slave_split || (expired && elig[0])) begin
          state_d = HANDOVER;
          last_d  = M2;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      pend_q  <= 2'b00;
      prio_q  <= 2'b00;
      last_q  <= M2;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      prio_q  <= prio_d;
      last_q  <= last_d;
    end
  end

  assign m1_grant      = (state_q == OWN_M1);
  assign m2_grant      = (state_q == OWN_M2);
  assign bus_busy      = m1_grant | m2_grant;
  assign split_pending = pend_q;
  assign arb_state     = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (RR_EN=1, HOLD_MAX=8) with hand-computed expectations.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       m1_request;
  logic       m2_request;
  logic       slave_split;
  logic [1:0] split_done;
  logic       m1_grant;
  logic       m2_grant;
  logic       bus_busy;
  logic [1:0] split_pending;
  logic [1:0] arb_state;

  int checks = 0;
  int errors = 0;

  // obs = {m1_grant, m2_grant, bus_busy, split_pending, arb_state}
  logic [6:0] obs;
  assign obs = {m1_grant, m2_grant, bus_busy, split_pending, arb_state};

  localparam logic [6:0] S_IDLE  = 7'b000_00_00;
  localparam logic [6:0] S_M1    = 7'b101_00_01;
  localparam logic [6:0] S_M2    = 7'b011_00_10;
  localparam logic [6:0] S_HO    = 7'b000_00_11;
  localparam logic [6:0] S_HO_P1 = 7'b000_01_11;
  localparam logic [6:0] S_M2_P1 = 7'b011_01_10;

  always #5 clk = ~clk;

  bus_arbiter #(
    .RR_EN    (1'b1),
    .HOLD_MAX (8),
    .TW       (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m1_request    (m1_request),
    .m2_request    (m2_request),
    .slave_split   (slave_split),
    .split_done    (split_done),
    .m1_grant      (m1_grant),
    .m2_grant      (m2_grant),
    .bus_busy      (bus_busy),
    .split_pending (split_pending),
    .arb_state     (arb_state)
  );

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks = checks + 1;
      if (m1_grant && m2_grant) begin
        errors = errors + 1;
        $display("FAIL mutex at %0t: m1_grant=%b m2_grant=%b required not both 1",
                 $time, m1_grant, m2_grant);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    m1_request  = 1'b0;
    m2_request  = 1'b0;
    slave_split = 1'b0;
    split_done  = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    m1_request  = 1'b1;
    m2_request  = 1'b1;
    slave_split = 1'b0;
    split_done  = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== S_IDLE) begin
      errors++;
      $display("FAIL reset_hold obs=%b exp=%b", obs, S_IDLE);
    end
    m1_request = 1'b0;
    m2_request = 1'b0;
    reset      = 1'b0;
    step();
    checks++;
    if (obs !== S_IDLE) begin
      errors++;
      $display("FAIL reset_release obs=%b exp=%b", obs, S_IDLE);
    end
  endtask

  task automatic test_single_m1();
    m1_request = 1'b1;
    step();
    checks++;
    if (obs !== S_M1) begin
      errors++;
      $display("FAIL t1_latency obs=%b exp=%b", obs, S_M1);
    end
    for (int i = 1; i < 5; i++) begin
      step();
      checks++;
      if (obs !== S_M1) begin
        errors++;
        $display("FAIL t1_hold_%0d obs=%b exp=%b", i, obs, S_M1);
      end
    end
    m1_request = 1'b0;
    step();
    checks++;
    if (obs !== S_HO) begin
      errors++;
      $display("FAIL t1_handover obs=%b exp=%b", obs, S_HO);
    end
    step();
    checks++;
    if (obs !== S_IDLE) begin
      errors++;
      $display("FAIL t1_idle obs=%b exp=%b", obs, S_IDLE);
    end
  endtask

  task automatic test_contention_rr();
    do_reset();
    m1_request = 1'b1;
    m2_request = 1'b1;
    step();
    checks++;
    if (obs !== S_M1) begin
      errors++;
      $display("FAIL t2_first_m1 obs=%b exp=%b", obs, S_M1);
    end
    step();
    step();
    checks++;
    if (obs !== S_M1) begin
      errors++;
      $display("FAIL t2_m1_keeps obs=%b exp=%b", obs, S_M1);
    end
    m1_request = 1'b0;
    step();
    checks++;
    if (obs !== S_HO) begin
      errors++;
      $display("FAIL t2_dead_cycle obs=%b exp=%b", obs, S_HO);
    end
    step();
    checks++;
    if (obs !== S_M2) begin
      errors++;
      $display("FAIL t2_m2_granted obs=%b exp=%b", obs, S_M2);
    end
    m2_request = 1'b0;
    step();
    step();
    checks++;
    if (obs !== S_IDLE) begin
      errors++;
      $display("FAIL t2_idle obs=%b exp=%b", obs, S_IDLE);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    m1_request = 1'b1;
    m2_request = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (obs !== S_M1) begin
        errors++;
        $display("FAIL t3_burst_%0d obs=%b exp=%b", i, obs, S_M1);
      end
    end
    step();
    checks++;
    if (obs !== S_HO) begin
      errors++;
      $display("FAIL t3_revoked obs=%b exp=%b", obs, S_HO);
    end
    step();
    checks++;
    if (obs !== S_M2) begin
      errors++;
      $display("FAIL t3_m2_after_preempt obs=%b exp=%b", obs, S_M2);
    end
    m1_request = 1'b0;
    m2_request = 1'b0;
    step();
    step();
    checks++;
    if (obs !== S_IDLE) begin
      errors++;
      $display("FAIL t3_idle obs=%b exp=%b", obs, S_IDLE);
    end
  endtask

  task automatic test_split();
    do_reset();
    m1_request = 1'b1;
    step();
    checks++;
    if (obs !== S_M1) begin
      errors++;
      $display("FAIL t4_m1_owns obs=%b exp=%b", obs, S_M1);
    end
    m2_request  = 1'b1;
    slave_split = 1'b1;
    step();
    slave_split = 1'b0;
    checks++;
    if (obs !== S_HO_P1) begin
      errors++;
      $display("FAIL t4_split_parks obs=%b exp=%b", obs, S_HO_P1);
    end
    step();
    checks++;
    if (obs !== S_M2_P1) begin
      errors++;
      $display("FAIL t4_m2_takes_bus obs=%b exp=%b", obs, S_M2_P1);
    end
    step();
    step();
    checks++;
    if (obs !== S_M2_P1) begin
      errors++;
      $display("FAIL t4_m1_ignored obs=%b exp=%b", obs, S_M2_P1);
    end
    split_done = 2'b01;
    step();
    split_done = 2'b00;
    checks++;
    if (obs !== S_M2) begin
      errors++;
      $display("FAIL t4_split_done_clears obs=%b exp=%b", obs, S_M2);
    end
    split_done = 2'b10;
    step();
    split_done = 2'b00;
    checks++;
    if (obs !== S_M2) begin
      errors++;
      $display("FAIL t6_done_not_pending obs=%b exp=%b", obs, S_M2);
    end
    m2_request = 1'b0;
    step();
    checks++;
    if (obs !== S_HO) begin
      errors++;
      $display("FAIL t4_m2_release obs=%b exp=%b", obs, S_HO);
    end
    m2_request = 1'b1;
    step();
    checks++;
    if (obs !== S_M1) begin
      errors++;
      $display("FAIL t4_resume_prio obs=%b exp=%b", obs, S_M1);
    end
    m1_request = 1'b0;
    m2_request = 1'b0;
    step();
    step();
    checks++;
    if (obs !== S_IDLE) begin
      errors++;
      $display("FAIL t4_idle obs=%b exp=%b", obs, S_IDLE);
    end
  endtask

  task automatic test_reset_mid_transfer();
    do_reset();
    m1_request = 1'b1;
    m2_request = 1'b1;
    step();
    slave_split = 1'b1;
    step();
    slave_split = 1'b0;
    step();
    checks++;
    if (obs !== S_M2_P1) begin
      errors++;
      $display("FAIL t5_m2_owns obs=%b exp=%b", obs, S_M2_P1);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (obs !== S_IDLE) begin
      errors++;
      $display("FAIL t5_async_drop obs=%b exp=%b", obs, S_IDLE);
    end
    m1_request = 1'b0;
    m2_request = 1'b0;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (obs !== S_IDLE) begin
      errors++;
      $display("FAIL t5_after_reset obs=%b exp=%b", obs, S_IDLE);
    end
  endtask

  task automatic test_idle_stray_done();
    split_done = 2'b10;
    step();
    split_done = 2'b00;
    checks++;
    if (obs !== S_IDLE) begin
      errors++;
      $display("FAIL t6_idle_stray_done obs=%b exp=%b", obs, S_IDLE);
    end
    step();
    checks++;
    if (obs !== S_IDLE) begin
      errors++;
      $display("FAIL t6_idle_stays obs=%b exp=%b", obs, S_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_single_m1();
    test_contention_rr();
    test_preempt();
    test_split();
    test_reset_mid_transfer();
    test_idle_stray_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
